// File: rtl/freq_sched.sv
// freq_sched: two debounced keys step a rate select that paces a ROM
// playback strobe through a glitch-free divider, and show the rate in MHz
// on two active-low seven-segment digits.

`timescale 1ns/1ps

// Per-key synchronizer and IDLE/WAIT/HELD debouncer emitting one pulse per press.
module freq_sched_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sync1, sync2;
    logic             armed;
    logic             pressed;
    logic             pulse_nx;

    // Raw key is active-low; after synchronizing, pressed=1 means held down.
    assign pressed = ~sync2;

    // Synchronizer, FSM state, counter, one-shot pulse and release arming.
    // armed stays low until the key has been seen released after reset, so a
    // key held through reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            armed <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            sync1 <= key_n;
            sync2 <= sync1;
            state <= state_nx;
            cnt   <= cnt_nx;
            pulse <= pulse_nx;
            armed <= armed | ~pressed;
        end
    end

    // Next state: count a stable press, fire once on entry to HELD.
    always_comb begin
        // NOTE: defaults first so no branch leaves a variable unassigned (latch).
        state_nx = state;
        cnt_nx   = cnt;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pressed && armed) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                if (!pressed) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nx = HELD;
                    pulse_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!pressed) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// Top level: rate select, divider, ROM address counter and display.
module freq_sched #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_up,
    input  logic              key_dn,
    input  logic              run,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        sel,
    output logic              pending,
    output logic [6:0]        SEG_FREQ,
    output logic [6:0]        SEG_FREQ1
);
    logic       up_pulse, dn_pulse;
    logic [1:0] req_sel;
    logic [2:0] div_cnt;
    logic [2:0] div_last;
    logic       div_wrap;
    logic [6:0] tens_nx, units_nx;

    freq_sched_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_up),
        .pulse (up_pulse)
    );

    freq_sched_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_dn),
        .pulse (dn_pulse)
    );

    // Strobe on the first count of each divider period; never during reset.
    assign rom_en   = run & ~rst & (div_cnt == 3'd0);
    assign div_wrap = (div_cnt == div_last);

    // Last divider count of the active strobe period (period = 2^sel).
    always_comb begin
        div_last = 3'd0;
        case (sel)
            2'd0:    div_last = 3'd0;
            2'd1:    div_last = 3'd1;
            2'd2:    div_last = 3'd3;
            default: div_last = 3'd7;
        endcase
    end

    // MHz digits for the active select: 50, 25, 12, 06 (active-low gfedcba).
    always_comb begin
        tens_nx  = 7'b0010010;
        units_nx = 7'b1000000;
        case (sel)
            2'd0: begin tens_nx = 7'b0010010; units_nx = 7'b1000000; end
            2'd1: begin tens_nx = 7'b0100100; units_nx = 7'b0010010; end
            2'd2: begin tens_nx = 7'b1111001; units_nx = 7'b0100100; end
            default: begin tens_nx = 7'b1000000; units_nx = 7'b0000010; end
        endcase
    end

    // Requested/active select, divider, address counter, pending and display.
    // sel only follows req_sel at a period boundary (or while stopped), so a
    // strobe period in progress always runs to its full length.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_sel   <= 2'd0;
            sel       <= 2'd0;
            div_cnt   <= 3'd0;
            rom_addr  <= '0;
            pending   <= 1'b0;
            SEG_FREQ  <= 7'b0010010;
            SEG_FREQ1 <= 7'b1000000;
        end else begin
            if (up_pulse && !dn_pulse) begin
                req_sel <= req_sel + 2'd1;
            end else if (dn_pulse && !up_pulse) begin
                req_sel <= req_sel - 2'd1;
            end

            if (run) begin
                div_cnt <= div_wrap ? 3'd0 : div_cnt + 3'd1;
            end else begin
                div_cnt <= 3'd0;
            end

            if (!run || div_wrap) sel <= req_sel;

            if (rom_en) rom_addr <= rom_addr + ADDR_W'(1);

            pending   <= (req_sel != sel);
            SEG_FREQ  <= tens_nx;
            SEG_FREQ1 <= units_nx;
        end
    end
endmodule

// File: tb/tb_freq_sched.sv
// tb_freq_sched: randomized and directed stimulus for freq_sched, checked
// against a behavioural model through a scoreboard of expected outputs.

`timescale 1ns/1ps

module tb_freq_sched;
    localparam int D  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_up = 1'b1;
    logic          key_dn = 1'b1;
    logic          run = 1'b0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [1:0]    sel;
    logic          pending;
    logic [6:0]    seg_freq, seg_freq1;

    freq_sched #(.DEBOUNCE_CYC(D), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_up    (key_up),
        .key_dn    (key_dn),
        .run       (run),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .sel       (sel),
        .pending   (pending),
        .SEG_FREQ  (seg_freq),
        .SEG_FREQ1 (seg_freq1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [1:0]    sel;
        logic          pend;
        logic [6:0]    tens;
        logic [6:0]    units;
    } status_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    sel;
    } strobe_t;

    status_t st_q[$];
    strobe_t sb_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // Display digits indexed by rate select: "50", "25", "12", "06".
    logic [6:0] tens_tab  [4] = '{7'b0010010, 7'b0100100, 7'b1111001, 7'b1000000};
    logic [6:0] units_tab [4] = '{7'b1000000, 7'b0010010, 7'b0100100, 7'b0000010};

    // Behavioural model state.
    int m_sel, m_req, m_ph, m_addr, m_pend, m_disp;
    bit m_s1 [2];
    bit m_s2 [2];
    int m_run [2];
    bit m_armed [2];
    bit m_pulse [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs held this cycle.
    task automatic model_edge();
        bit pu, pd, en, wrap, raw, smp;
        int period;
        if (rst) begin
            m_sel = 0; m_req = 0; m_ph = 0; m_addr = 0; m_pend = 0; m_disp = 0;
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_run[k] = 0; m_armed[k] = 0; m_pulse[k] = 0;
            end
        end else begin
            pu     = m_pulse[0];
            pd     = m_pulse[1];
            period = 1 << m_sel;
            en     = run && (m_ph == 0);
            wrap   = run && (m_ph == period - 1);
            m_disp = m_sel;
            m_pend = (m_req != m_sel) ? 1 : 0;
            m_addr = (m_addr + (en ? 1 : 0)) % (1 << AW);
            m_ph   = run ? (m_ph + 1) % period : 0;
            if (!run || wrap) m_sel = m_req;
            if (pu && !pd)      m_req = (m_req + 1) % 4;
            else if (pd && !pu) m_req = (m_req + 3) % 4;
            // A press is accepted once D+1 consecutive pressed samples follow
            // a released sample seen since reset.
            for (int k = 0; k < 2; k++) begin
                raw = (k == 0) ? key_up : key_dn;
                smp = !m_s2[k];
                if (!smp) begin
                    m_run[k] = 0; m_armed[k] = 1; m_pulse[k] = 0;
                end else if (m_armed[k]) begin
                    m_run[k]++;
                    m_pulse[k] = (m_run[k] == D + 1);
                end else begin
                    m_pulse[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = raw;
            end
        end
    endtask

    // One clock cycle: update model at the edge, drive inputs, queue expectations.
    task automatic step(input bit r_run, input bit r_rst, input bit r_up, input bit r_dn);
        status_t s;
        strobe_t b;
        @(posedge clk);
        model_edge();
        #1;
        run = r_run; rst = r_rst; key_up = r_up; key_dn = r_dn;
        s.en    = r_run && !r_rst && (m_ph == 0);
        s.addr  = AW'(m_addr);
        s.sel   = 2'(m_sel);
        s.pend  = 1'(m_pend);
        s.tens  = tens_tab[m_disp];
        s.units = units_tab[m_disp];
        st_q.push_back(s);
        if (s.en) begin
            b.addr = AW'(m_addr);
            b.sel  = 2'(m_sel);
            sb_q.push_back(b);
        end
    endtask

    task automatic hold(input int n, input bit r_run, input bit up_low, input bit dn_low);
        for (int i = 0; i < n; i++) step(r_run, 1'b0, !up_low, !dn_low);
    endtask

    // Monitor: compare per-cycle outputs and every strobe against the queues.
    initial begin
        status_t e;
        strobe_t b;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check("rom_en",    32'(rom_en),    32'(e.en));
                check("rom_addr",  32'(rom_addr),  32'(e.addr));
                check("sel",       32'(sel),       32'(e.sel));
                check("pending",   32'(pending),   32'(e.pend));
                check("SEG_FREQ",  32'(seg_freq),  32'(e.tens));
                check("SEG_FREQ1", 32'(seg_freq1), 32'(e.units));
            end
            if (rom_en) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL strobe: unexpected rom_en at addr %0d, none expected", rom_addr);
                end else begin
                    b = sb_q.pop_front();
                    check("strobe_addr", 32'(rom_addr), 32'(b.addr));
                    check("strobe_sel",  32'(sel),      32'(b.sel));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a, len;
        bit r;

        // Reset state.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("reset_sel",       32'(sel),       32'd0);
        check("reset_addr",      32'(rom_addr),  32'd0);
        check("reset_rom_en",    32'(rom_en),    32'd0);
        check("reset_pending",   32'(pending),   32'd0);
        check("reset_SEG_FREQ",  32'(seg_freq),  32'b0010010);
        check("reset_SEG_FREQ1", 32'(seg_freq1), 32'b1000000);

        // Full-rate playback with address wrap.
        hold(20, 1'b1, 1'b0, 1'b0);

        // Valid up press: sel 0 -> 1, display "25".
        hold(10, 1'b1, 1'b1, 1'b0);
        hold(20, 1'b1, 1'b0, 1'b0);
        check("up_sel",       32'(sel),       32'd1);
        check("up_SEG_FREQ",  32'(seg_freq),  32'b0100100);
        check("up_SEG_FREQ1", 32'(seg_freq1), 32'b0010010);

        // Too-short press: no change.
        hold(3, 1'b1, 1'b1, 1'b0);
        hold(20, 1'b1, 1'b0, 1'b0);
        check("short_sel", 32'(sel), 32'd1);

        // Down twice: 1 -> 0 -> 3 (wrap), display "06".
        hold(10, 1'b1, 1'b0, 1'b1);
        hold(20, 1'b1, 1'b0, 1'b0);
        check("dn1_sel", 32'(sel), 32'd0);
        hold(10, 1'b1, 1'b0, 1'b1);
        hold(20, 1'b1, 1'b0, 1'b0);
        check("dn2_sel",       32'(sel),       32'd3);
        check("dn2_SEG_FREQ",  32'(seg_freq),  32'b1000000);
        check("dn2_SEG_FREQ1", 32'(seg_freq1), 32'b0000010);

        // Up at sel 3 wraps to 0 at a period boundary, display "50".
        hold(3, 1'b1, 1'b0, 1'b0);
        hold(10, 1'b1, 1'b1, 1'b0);
        hold(20, 1'b1, 1'b0, 1'b0);
        check("wrap_sel",      32'(sel),      32'd0);
        check("wrap_SEG_FREQ", 32'(seg_freq), 32'b0010010);

        // Both keys together: ignored.
        hold(10, 1'b1, 1'b1, 1'b1);
        hold(20, 1'b1, 1'b0, 1'b0);
        check("both_sel", 32'(sel), 32'd0);

        // Key held through reset produces no press.
        hold(3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        hold(12, 1'b1, 1'b1, 1'b0);
        hold(20, 1'b1, 1'b0, 1'b0);
        check("held_rst_sel", 32'(sel), 32'd0);

        // Stopped: select follows immediately, address holds.
        hold(10, 1'b0, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b0, 1'b0);
        check("stopped_sel", 32'(sel), 32'd1);
        hold(5, 1'b1, 1'b0, 1'b0);

        // Randomized phase.
        for (int i = 0; i < 150; i++) begin
            a   = $urandom_range(0, 9);
            len = $urandom_range(1, 14);
            r   = ($urandom_range(0, 3) != 0);
            case (a)
                0: for (int j = 0; j < 1 + len % 2; j++) step(r, 1'b1, 1'b1, 1'b1);
                1, 2, 3: hold(len, r, 1'b1, 1'b0);
                4, 5, 6: hold(len, r, 1'b0, 1'b1);
                7: hold(len, r, 1'b1, 1'b1);
                8: for (int j = 0; j < len; j++) step(r, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
                default: hold(len, r, 1'b0, 1'b0);
            endcase
            hold($urandom_range(1, 12), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        end

        hold(4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("status_queue_drained", 32'(st_q.size()), 32'd0);
        check("strobe_queue_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
